// File: rtl/fsqrt_nr_sequencer.sv
// rtl/fsqrt_nr_sequencer.sv - double sqrt sequencer: rsqrt seed, ITERS Newton-Raphson passes, final x*y multiply
// Optional FSQRT_RSQRT_OUT_EN adds op_rsqrt to return 1/sqrt(x) directly from the last NR pass.
module fsqrt_nr_sequencer #(
  parameter int unsigned ITERS     = 4,
  parameter int unsigned STEP_WAIT = 2,
  parameter logic [63:0] MAGIC     = 64'h5FE6EB50C7B537A9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] x_in,
`ifdef FSQRT_RSQRT_OUT_EN
  input  logic        op_rsqrt,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [63:0] dp_x,
  output logic [63:0] dp_y,
  input  logic [63:0] dp_y_nr,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  input  logic [63:0] mul_p
);

  localparam int unsigned CW = (STEP_WAIT > 1) ? $clog2(STEP_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_WAIT - 1);
  localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef enum logic [2:0] {IDLE, SEED, STEP, FINAL, DONE} state_t;

  state_t        state_q, state_d;
  logic [63:0]   x_q, x_d, y_q, y_d, result_q, result_d;
  logic [63:0]   dp_x_q, dp_x_d, dp_y_q, dp_y_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [3:0]    iter_q, iter_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsqrt;
  logic          x_nan, x_zero, x_inf, special;
  logic [63:0]   special_val;

`ifdef FSQRT_RSQRT_OUT_EN
  logic rsqrt_q, rsqrt_d;
  assign rsqrt = rsqrt_q;
`else
  assign rsqrt = 1'b0;
`endif

  assign x_nan  = (x_q[62:52] == 11'h7FF) && (x_q[51:0] != 52'b0);
  assign x_inf  = (x_q[62:52] == 11'h7FF) && (x_q[51:0] == 52'b0);
  assign x_zero = (x_q[62:52] == 11'h000);

  // Subnormals are flushed and treated as signed zero, ahead of the negative check.
  always_comb begin
    special     = 1'b1;
    special_val = '0;
    if (x_nan)
      special_val = x_q | 64'h0008000000000000;
    else if (x_zero)
      special_val = rsqrt ? {x_q[63], 11'h7FF, 52'b0} : {x_q[63:52], 52'b0};
    else if (x_q[63])
      special_val = QNAN;
    else if (x_inf)
      special_val = rsqrt ? 64'b0 : x_q;
    else
      special = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dp_x_d   = dp_x_q;
    dp_y_d   = dp_y_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
`ifdef FSQRT_RSQRT_OUT_EN
    rsqrt_d  = rsqrt_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        x_d     = x_in;
`ifdef FSQRT_RSQRT_OUT_EN
        rsqrt_d = op_rsqrt;
`endif
        state_d = SEED;
      end
      SEED: if (special) begin
        result_d = special_val;
        state_d  = DONE;
      end else begin
        y_d     = MAGIC - (x_q >> 1);
        iter_d  = '0;
        cnt_d   = '0;
        state_d = STEP;
      end
      STEP: if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        y_d    = dp_y_nr;
        iter_d = iter_q + 4'd1;
        if (iter_q == ITER_LAST) begin
          if (rsqrt) begin
            result_d = dp_y_nr;
            state_d  = DONE;
          end else begin
            state_d = FINAL;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      FINAL: if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        result_d = mul_p;
        state_d  = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Datapath operands are registered from the upcoming state so they are stable for the whole pass.
    if (state_d == STEP) begin
      dp_x_d = x_q;
      dp_y_d = y_d;
    end
    if (state_d == FINAL) begin
      mul_a_d = x_q;
      mul_b_d = y_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dp_x_q   <= '0;
      dp_y_q   <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
`ifdef FSQRT_RSQRT_OUT_EN
      rsqrt_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      iter_q   <= iter_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dp_x_q   <= dp_x_d;
      dp_y_q   <= dp_y_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
`ifdef FSQRT_RSQRT_OUT_EN
      rsqrt_q  <= rsqrt_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign dp_x   = dp_x_q;
  assign dp_y   = dp_y_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule
